// File: rtl/decode_sequencer_if.sv
// Decode-stage bus: instruction handshake in, EX/MEM/WB control bundles and sequencing flags out.
interface decode_sequencer_if #(
    parameter int ALUOP_W = 4
);
    localparam int OPC_W = ALUOP_W + 2;

    logic               stall;
    logic               instr_valid;
    logic [OPC_W-1:0]   instr;
    logic [ALUOP_W+1:0] ex_signals;
    logic [3:0]         mem_signals;
    logic [2:0]         wb_signals;
    logic               flush;
    logic               busy;
    logic               swap_phase;
    logic               illegal;

    modport master (
        output stall, instr_valid, instr,
        input  ex_signals, mem_signals, wb_signals, flush, busy, swap_phase, illegal
    );

    modport slave (
        input  stall, instr_valid, instr,
        output ex_signals, mem_signals, wb_signals, flush, busy, swap_phase, illegal
    );
endinterface

// File: rtl/decode_sequencer.sv
// Registered decode controller: opcode -> EX/MEM/WB bundles one cycle later,
// with immediate-word (LDM/imm ALU) and two-phase SWAP sequencing.
module decode_sequencer #(
    parameter int ALUOP_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    decode_sequencer_if.slave dec
);
    localparam int OPC_W = ALUOP_W + 2;
    localparam logic [ALUOP_W-1:0] FUNC_ZERO = '0;
    localparam logic [ALUOP_W-1:0] FUNC_ONE  = ALUOP_W'(1);

    typedef enum logic [1:0] {
        S_DEC = 2'd0,
        S_IMM = 2'd1,
        S_SWP = 2'd2
    } state_t;

    state_t             r_state;
    logic [ALUOP_W+1:0] r_ex;
    logic [3:0]         r_mem;
    logic [2:0]         r_wb;
    logic               r_flush;
    logic               r_busy;
    logic               r_swap_phase;
    logic               r_illegal;

    state_t             w_next_state;
    logic [ALUOP_W+1:0] w_ex;
    logic [3:0]         w_mem;
    logic [2:0]         w_wb;
    logic               w_flush;
    logic               w_busy;
    logic               w_swap_phase;
    logic               w_illegal;
    logic [1:0]         w_class;
    logic [ALUOP_W-1:0] w_func;

    assign w_class = dec.instr[OPC_W-1:OPC_W-2];
    assign w_func  = dec.instr[ALUOP_W-1:0];

    always_comb begin
        w_next_state = r_state;
        w_ex         = '0;
        w_mem        = '0;
        w_wb         = '0;
        w_flush      = 1'b0;
        w_busy       = 1'b0;
        w_swap_phase = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_DEC: begin
                if (dec.instr_valid) begin
                    case (w_class)
                        2'b00: begin
                            if (w_func != FUNC_ZERO) begin
                                w_ex = {1'b1, w_func, 1'b0};
                                w_wb = 3'b101;
                            end
                        end
                        2'b01: begin
                            w_next_state = S_IMM;
                            w_flush      = 1'b1;
                            if (w_func == FUNC_ZERO) begin
                                w_wb = 3'b110;
                            end else begin
                                w_ex = {1'b1, w_func, w_func[ALUOP_W-1]};
                                w_wb = 3'b101;
                            end
                        end
                        2'b10: begin
                            if (w_func == FUNC_ZERO) begin
                                w_mem = 4'b1000;
                                w_wb  = 3'b100;
                            end else if (w_func == FUNC_ONE) begin
                                w_mem = 4'b0110;
                            end else begin
                                w_illegal = 1'b1;
                            end
                        end
                        default: begin
                            if (w_func == FUNC_ZERO) begin
                                w_ex         = {1'b1, {ALUOP_W{1'b1}}, 1'b0};
                                w_wb         = 3'b101;
                                w_busy       = 1'b1;
                                w_next_state = S_SWP;
                            end else begin
                                w_illegal = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_IMM: begin
                // Flush stays up until the immediate word is actually consumed.
                if (dec.instr_valid) begin
                    w_next_state = S_DEC;
                end else begin
                    w_flush = 1'b1;
                end
            end
            S_SWP: begin
                w_ex         = r_ex;
                w_mem        = r_mem;
                w_wb         = r_wb;
                w_swap_phase = 1'b1;
                w_next_state = S_DEC;
            end
            default: w_next_state = S_DEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_DEC;
            r_ex         <= '0;
            r_mem        <= '0;
            r_wb         <= '0;
            r_flush      <= 1'b0;
            r_busy       <= 1'b0;
            r_swap_phase <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (!dec.stall) begin
            r_state      <= w_next_state;
            r_ex         <= w_ex;
            r_mem        <= w_mem;
            r_wb         <= w_wb;
            r_flush      <= w_flush;
            r_busy       <= w_busy;
            r_swap_phase <= w_swap_phase;
            r_illegal    <= w_illegal;
        end
    end

    assign dec.ex_signals  = r_ex;
    assign dec.mem_signals = r_mem;
    assign dec.wb_signals  = r_wb;
    assign dec.flush       = r_flush;
    assign dec.busy        = r_busy;
    assign dec.swap_phase  = r_swap_phase;
    assign dec.illegal     = r_illegal;
endmodule

// File: tb/tb_decode_sequencer.sv
// Directed-vector bench for decode_sequencer (ALUOP_W=4): table of per-edge stimulus
// and expected outputs, plus hand-written reset/back-to-back sequences.
module tb_decode_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    decode_sequencer_if #(.ALUOP_W(4)) dif ();

    decode_sequencer #(.ALUOP_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcodes {class, func}
    localparam logic [5:0] OP_NOP  = 6'b00_0000;
    localparam logic [5:0] OP_NOT  = 6'b00_0001;
    localparam logic [5:0] OP_ADD  = 6'b00_0010;
    localparam logic [5:0] OP_LDM  = 6'b01_0000;
    localparam logic [5:0] OP_IA1  = 6'b01_1011;
    localparam logic [5:0] OP_IA2  = 6'b01_0011;
    localparam logic [5:0] OP_LDD  = 6'b10_0000;
    localparam logic [5:0] OP_STD  = 6'b10_0001;
    localparam logic [5:0] OP_ILL  = 6'b10_0101;
    localparam logic [5:0] OP_ILL2 = 6'b11_0001;
    localparam logic [5:0] OP_SWAP = 6'b11_0000;

    // Bundles {ex[5:0], mem[3:0], wb[2:0]}
    localparam logic [12:0] B_NOP = 13'b0;
    localparam logic [12:0] B_ADD = {6'b100100, 4'b0000, 3'b101};
    localparam logic [12:0] B_NOT = {6'b100010, 4'b0000, 3'b101};
    localparam logic [12:0] B_LDM = {6'b000000, 4'b0000, 3'b110};
    localparam logic [12:0] B_IA1 = {6'b110111, 4'b0000, 3'b101};
    localparam logic [12:0] B_IA2 = {6'b100110, 4'b0000, 3'b101};
    localparam logic [12:0] B_SWP = {6'b111110, 4'b0000, 3'b101};
    localparam logic [12:0] B_STD = {6'b000000, 4'b0110, 3'b000};
    localparam logic [12:0] B_LDD = {6'b000000, 4'b1000, 3'b100};

    // Flags {flush, busy, swap_phase, illegal}
    localparam logic [3:0] F_0  = 4'b0000;
    localparam logic [3:0] F_FL = 4'b1000;
    localparam logic [3:0] F_BS = 4'b0100;
    localparam logic [3:0] F_SP = 4'b0010;
    localparam logic [3:0] F_IL = 4'b0001;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        vld;
        logic [5:0]  instr;
        logic [12:0] bundle;
        logic [3:0]  flags;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic v, input logic [5:0] in,
                       input logic [12:0] b, input logic [3:0] f);
        vec_t e;
        e.rst_n  = r;
        e.stall  = s;
        e.vld    = v;
        e.instr  = in;
        e.bundle = b;
        e.flags  = f;
        tbl.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic [5:0] in);
        @(negedge clk);
        rst_n           = r;
        dif.stall       = s;
        dif.instr_valid = v;
        dif.instr       = in;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [12:0] b, input logic [3:0] f);
        logic [16:0] got;
        logic [16:0] exp;
        got = {dif.ex_signals, dif.mem_signals, dif.wb_signals,
               dif.flush, dif.busy, dif.swap_phase, dif.illegal};
        exp = {b, f};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got ex=%b mem=%b wb=%b fl/bs/sp/il=%b required ex=%b mem=%b wb=%b fl/bs/sp/il=%b",
                     name, got[16:11], got[10:7], got[6:4], got[3:0],
                     exp[16:11], exp[10:7], exp[6:4], exp[3:0]);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        dif.stall       = 1'b0;
        dif.instr_valid = 1'b0;
        dif.instr       = '0;

        //   rst  stall vld  instr     bundle  flags
        add(1'b0, 1'b0, 1'b0, OP_NOP,  B_NOP, F_0);   // reset state
        add(1'b0, 1'b1, 1'b1, OP_ADD,  B_NOP, F_0);   // reset beats stall
        add(1'b1, 1'b0, 1'b1, OP_ADD,  B_ADD, F_0);
        add(1'b1, 1'b0, 1'b0, OP_ADD,  B_NOP, F_0);   // invalid -> NOP
        add(1'b1, 1'b0, 1'b1, OP_LDM,  B_LDM, F_FL);
        add(1'b1, 1'b0, 1'b1, 6'h2A,   B_NOP, F_0);   // immediate, not decoded
        add(1'b1, 1'b0, 1'b1, OP_IA1,  B_IA1, F_FL);
        add(1'b1, 1'b0, 1'b0, OP_NOP,  B_NOP, F_FL);  // waiting for immediate
        add(1'b1, 1'b1, 1'b1, 6'h30,   B_NOP, F_FL);  // stalled, not consumed
        add(1'b1, 1'b0, 1'b1, 6'h30,   B_NOP, F_0);   // SWAP-looking immediate
        add(1'b1, 1'b0, 1'b1, OP_SWAP, B_SWP, F_BS);
        add(1'b1, 1'b0, 1'b1, OP_ADD,  B_SWP, F_SP);  // held ADD ignored
        add(1'b1, 1'b0, 1'b1, OP_ADD,  B_ADD, F_0);
        add(1'b1, 1'b0, 1'b1, OP_STD,  B_STD, F_0);
        add(1'b1, 1'b1, 1'b1, OP_LDM,  B_STD, F_0);
        add(1'b1, 1'b1, 1'b1, OP_LDM,  B_STD, F_0);
        add(1'b1, 1'b1, 1'b1, OP_LDM,  B_STD, F_0);
        add(1'b1, 1'b0, 1'b0, OP_LDM,  B_NOP, F_0);   // LDM was never accepted
        add(1'b1, 1'b0, 1'b1, OP_ILL,  B_NOP, F_IL);
        add(1'b1, 1'b0, 1'b1, OP_NOP,  B_NOP, F_0);
        add(1'b1, 1'b0, 1'b1, OP_ILL,  B_NOP, F_IL);
        add(1'b1, 1'b1, 1'b1, OP_ADD,  B_NOP, F_IL);  // illegal held by stall
        add(1'b1, 1'b1, 1'b0, OP_ADD,  B_NOP, F_IL);
        add(1'b1, 1'b0, 1'b0, OP_ADD,  B_NOP, F_0);
        add(1'b1, 1'b0, 1'b1, OP_LDD,  B_LDD, F_0);
        add(1'b1, 1'b0, 1'b1, OP_IA2,  B_IA2, F_FL);
        add(1'b1, 1'b0, 1'b1, 6'h3F,   B_NOP, F_0);
        add(1'b1, 1'b0, 1'b1, OP_SWAP, B_SWP, F_BS);
        add(1'b1, 1'b1, 1'b0, OP_NOP,  B_SWP, F_BS);  // stall in SWP
        add(1'b1, 1'b0, 1'b0, OP_NOP,  B_SWP, F_SP);
        add(1'b1, 1'b0, 1'b1, OP_SWAP, B_SWP, F_BS);
        add(1'b0, 1'b0, 1'b1, OP_SWAP, B_NOP, F_0);   // reset mid-SWP
        add(1'b1, 1'b0, 1'b1, OP_NOT,  B_NOT, F_0);
        add(1'b1, 1'b0, 1'b1, OP_ILL2, B_NOP, F_IL);
        add(1'b1, 1'b0, 1'b0, OP_NOP,  B_NOP, F_0);

        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].stall, tbl[i].vld, tbl[i].instr);
            check($sformatf("vec%0d", i), tbl[i].bundle, tbl[i].flags);
        end

        // Reset during IMM drops the pending immediate: next 0x2A is an opcode.
        step(1'b1, 1'b0, 1'b1, OP_LDM);
        check("seq_ldm", B_LDM, F_FL);
        step(1'b0, 1'b0, 1'b1, 6'h2A);
        check("seq_rst_imm", B_NOP, F_0);
        step(1'b1, 1'b0, 1'b1, 6'h2A);
        check("seq_2a_illegal", B_NOP, F_IL);

        // Back-to-back accepts, no bubbles.
        step(1'b1, 1'b0, 1'b1, OP_ADD);
        check("seq_b2b_add", B_ADD, F_0);
        step(1'b1, 1'b0, 1'b1, OP_NOT);
        check("seq_b2b_not", B_NOT, F_0);
        step(1'b1, 1'b0, 1'b1, OP_STD);
        check("seq_b2b_std", B_STD, F_0);
        step(1'b1, 1'b0, 1'b1, OP_SWAP);
        check("seq_swap0", B_SWP, F_BS);
        step(1'b1, 1'b0, 1'b1, OP_LDD);
        check("seq_swap1", B_SWP, F_SP);
        step(1'b1, 1'b0, 1'b1, OP_LDD);
        check("seq_ldd", B_LDD, F_0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
